// File: rtl/dmem_responder.sv
// Memory-stage data responder: word storage with byte enables, misaligned/out-of-range flagging.
// Latency: request to RespValidM is WAIT_CYCLES+1 cycles; ReadDataM/AccErrM registered with the response.
// Backpressure: StallM holds the M stage from request until the response cycle; one request in flight.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValidM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic [31:0] ReadDataM,
  output logic        RespValidM,
  output logic        StallM,
  output logic        AccErrM
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          c_we;
  logic          c_err;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_be;
  logic [AW-1:0] c_idx;

  assign accept     = (state == IDLE) && ReqValidM;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
  assign StallM     = accept || (state == WAIT);

  // With no wait cycles the commit happens on the accept edge, so use the live request.
  assign c_we    = accept ? MemWriteM  : lat_we;
  assign c_addr  = accept ? ALUOutM    : lat_addr;
  assign c_wdata = accept ? WriteDataM : lat_wdata;
  assign c_be    = accept ? ByteEnM    : lat_be;

  assign c_err = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign c_idx = c_addr[AW+1:2];

  // Storage is deliberately left out of the reset branch: reset only blocks writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      ReadDataM  <= '0;
      RespValidM <= 1'b0;
      AccErrM    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
    end else begin
      RespValidM <= enter_resp;
      case (state)
        IDLE: begin
          if (ReqValidM) begin
            lat_we    <= MemWriteM;
            lat_addr  <= ALUOutM;
            lat_wdata <= WriteDataM;
            lat_be    <= ByteEnM;
            AccErrM   <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        AccErrM <= c_err;
        if (!c_we) begin
          ReadDataM <= c_err ? 32'd0 : mem[c_idx];
        end else if (!c_err) begin
          for (int i = 0; i < 4; i++) begin
            if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/zero-wait sequences, randomized run vs. byte-lane model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rd;
  logic        rv, stall, err;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic [31:0] rd0;
  logic        rv0, stall0, err0;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(rst_n), .ReqValidM(req), .MemWriteM(we), .ALUOutM(addr),
    .WriteDataM(wdata), .ByteEnM(be), .ReadDataM(rd), .RespValidM(rv),
    .StallM(stall), .AccErrM(err)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .ReqValidM(req0), .MemWriteM(we0), .ALUOutM(addr0),
    .WriteDataM(wdata0), .ByteEnM(be0), .ReadDataM(rd0), .RespValidM(rv0),
    .StallM(stall0), .AccErrM(err0)
  );

  int total  = 0;
  int passed = 0;
  bit sel    = 1'b0;   // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0 instance

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] hold;          // expected ReadDataM of the main instance
  logic [31:0] model [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Called at a negedge; returns at a negedge with the request dropped.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] r, output logic e,
                        output int lat, output int stalls, output logic e_acc);
    logic got;
    got = 1'b0; lat = -1; stalls = 0; r = '0; e = 1'b0; e_acc = 1'b0;
    if (!sel) begin req = 1'b1; we = w; addr = a; wdata = d; be = b; end
    else begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b; end
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (sel ? stall0 : stall) stalls++;
      if (c == 1) e_acc = sel ? err0 : err;
      if (sel ? rv0 : rv) begin
        got = 1'b1; lat = c; r = sel ? rd0 : rd; e = sel ? err0 : err;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    req = 1'b0; req0 = 1'b0;
  endtask

  task automatic run_main(input string nm, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] r; logic e, ea; int lat, st;
    do_req(w, a, d, b, r, e, lat, st, ea);
    chk({nm, " latency"}, lat, 3);
    chk({nm, " stall cycles"}, st, 3);
    chk({nm, " err after accept"}, {31'd0, ea}, 0);
    chk({nm, " err"}, {31'd0, e}, {31'd0, exp_err});
    if (!w) hold = exp_rd;
    chk({nm, " rdata"}, r, hold);
  endtask

  initial begin
    logic [31:0] r; logic e, ea; int lat, st, seen;

    rst_n = 1'b0;
    req = 1'b1; we = 1'b0; addr = 32'h40; wdata = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    hold = '0;

    // Reset with a request held
    repeat (2) @(negedge clk);
    #1;
    chk("reset rdata", rd, 0);
    chk("reset respvalid", {31'd0, rv}, 0);
    chk("reset accerr", {31'd0, err}, 0);
    chk("reset stall with req", {31'd0, stall}, 1);
    chk("reset respvalid0", {31'd0, rv0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_main("first after reset", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'b0001, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEAA, 1'b0};
    tbl[4]  = '{1'b0, 32'h13,  32'h0,        4'b0000, 32'h0,        1'b1};
    tbl[5]  = '{1'b0, 32'h100, 32'h0,        4'b0000, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h100, 32'h12345678, 4'b1111, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 32'h0,   32'h0,        4'b0000, 32'hCAFEF00D, 1'b0};
    tbl[8]  = '{1'b1, 32'h14,  32'hAABBCCDD, 4'b1111, 32'h0,        1'b0};
    tbl[9]  = '{1'b1, 32'h14,  32'h55555555, 4'b0000, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 32'h14,  32'h0,        4'b0000, 32'hAABBCCDD, 1'b0};
    tbl[11] = '{1'b1, 32'h18,  32'hA1B2C3D4, 4'b1111, 32'h0,        1'b0};
    tbl[12] = '{1'b1, 32'h18,  32'h00000000, 4'b0101, 32'h0,        1'b0};
    tbl[13] = '{1'b0, 32'h18,  32'h0,        4'b0000, 32'hA100C300, 1'b0};
    tbl[14] = '{1'b1, 32'h12,  32'h77777777, 4'b1111, 32'h0,        1'b1};
    tbl[15] = '{1'b1, 32'h20,  32'h11111111, 4'b1111, 32'h0,        1'b0};

    for (int i = 0; i < 16; i++) begin
      run_main($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b,
               tbl[i].exp_rd, tbl[i].exp_err);
    end
    run_main("load after misaligned store", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    run_main("store last word", 1'b1, 32'hFC, 32'h0F0F0F0F, 4'hF, 32'h0, 1'b0);
    run_main("load last word", 1'b0, 32'hFC, 32'h0, 4'h0, 32'h0F0F0F0F, 1'b0);

    // Reset during WAIT drops the store
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h22222222; be = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    hold = '0;
    chk("reset in wait respvalid", {31'd0, rv}, 0);
    chk("reset in wait rdata", rd, 0);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (rv) seen++;
    end
    chk("no response after reset", seen, 0);
    @(negedge clk);
    run_main("load after dropped store", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0);

    // Zero-wait instance
    sel = 1'b1;
    do_req(1'b1, 32'h0, 32'h0A0A0A0A, 4'hF, r, e, lat, st, ea);
    chk("w0 store latency", lat, 1);
    chk("w0 store stalls", st, 1);
    do_req(1'b1, 32'h4, 32'h0B0B0B0B, 4'hF, r, e, lat, st, ea);
    chk("w0 store2 latency", lat, 1);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    #1;
    chk("w0 stall c0", {31'd0, stall0}, 1);
    @(negedge clk); #1;
    chk("w0 stall c1", {31'd0, stall0}, 0);
    chk("w0 resp c1", {31'd0, rv0}, 1);
    chk("w0 rdata 0x0", rd0, 32'h0A0A0A0A);
    addr0 = 32'h4;
    @(negedge clk); #1;
    chk("w0 stall c2", {31'd0, stall0}, 1);
    chk("w0 resp c2", {31'd0, rv0}, 0);
    @(negedge clk); #1;
    chk("w0 stall c3", {31'd0, stall0}, 0);
    chk("w0 resp c3", {31'd0, rv0}, 1);
    chk("w0 rdata 0x4", rd0, 32'h0B0B0B0B);
    req0 = 1'b0;
    @(negedge clk);
    sel = 1'b0;

    // Randomized run against a byte-lane memory model
    for (int i = 0; i < 64; i++) begin
      model[i] = $urandom;
      run_main($sformatf("init%0d", i), 1'b1, 32'(i * 4), model[i], 4'hF, 32'h0, 1'b0);
    end
    for (int n = 0; n < 150; n++) begin
      int unsigned a, k;
      logic        w, ex_err;
      logic [31:0] d, ex_rd;
      logic [3:0]  b;
      k = $urandom_range(0, 9);
      if (k == 0)      a = $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
      else if (k == 1) a = (k == 1 && $urandom_range(0, 1) == 1) ? 256 + $urandom_range(0, 63) * 4
                                                                 : ($urandom & 32'hFFFF_FFFC) | 32'h0000_1000;
      else             a = $urandom_range(0, 63) * 4;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      ex_err = (a % 4 != 0) || (a >= 4 * 64);
      ex_rd  = 32'h0;
      if (!ex_err) begin
        if (w) begin
          for (int j = 0; j < 4; j++)
            if (b[j]) model[a / 4][8*j +: 8] = d[8*j +: 8];
        end else begin
          ex_rd = model[a / 4];
        end
      end
      run_main($sformatf("rnd%0d", n), w, a, d, b, ex_rd, ex_err);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
